decimal_entry: RTL and testbench
================================

Name: decimal_entry

Overview:
- Inverse of the program-counter display path: accepts a signed decimal number keyed in one digit at a time from board buttons or switches.
- Holds the digits as BCD, converts them serially to a 9-bit two's-complement value, and presents that value with a one-cycle valid pulse.
- Echoes the BCD digits in progress so they can drive the existing 7-segment display modules during entry.

Parameters:
- WIDTH, 9, output value width; two's complement; range -256..255.
- NDIGITS, 3, maximum decimal digits held (hundred, ten, unit).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- digit  input  4  BCD digit value; sampled when digit_key rises.
- digit_key  input  1  level from button/switch; its rising edge enters digit.
- sign_key  input  1  rising edge toggles the pending sign.
- enter_key  input  1  rising edge starts conversion.
- clear_key  input  1  rising edge discards the entry and clears error.
- value_out  output  WIDTH  last successfully converted value, two's complement.
- value_valid  output  1  one-cycle pulse when value_out updates.
- error  output  1  last conversion was out of range; sticky.
- busy  output  1  high while in the CONVERT state.
- unit  output  4  BCD units digit of the entry in progress.
- ten  output  4  BCD tens digit of the entry in progress.
- hundred  output  4  BCD hundreds digit of the entry in progress.
- negative  output  1  pending sign of the entry in progress.

Behaviour:
- Reset values: all outputs 0; state IDLE; digit count 0; key-history registers 0.
- Edge detection:
  - Each key input is registered each cycle.
  - Event = input high & previous sample low. It is acted on at the same clock edge.
  - Holding a key high yields exactly one event.
- States: IDLE, CONVERT.
- Event priority within one cycle: clear > enter > digit > sign. Only the highest-priority event is taken; the others are dropped.
- IDLE, digit event:
  - If digit > 9, ignored.
  - If count == NDIGITS, ignored; no shift, no overwrite.
  - Otherwise shift left: hundred<=ten, ten<=unit, unit<=digit; count+1.
  - error is cleared.
- IDLE, sign event: negative toggles.
- IDLE, clear event: digits, count, negative and error all go to 0. value_out is retained.
- IDLE, enter event: go to CONVERT, busy=1, accumulator=0.
- CONVERT timing:
  - Cycles 1..3 each compute acc <= acc*10 + digit, using hundred, then ten, then unit (leading zeros are harmless).
  - acc is 10 bits unsigned, magnitude 0..999.
  - *10 is implemented as (acc<<3)+(acc<<1); no multiplier.
- CONVERT, at the 4th edge after entry:
  - Range check: positive valid if acc ≤ 255; negative valid if acc ≤ 256.
  - If valid: value_out <= negative ? -acc : acc; value_valid=1 for that one cycle; error=0.
  - If invalid: value_out unchanged; value_valid stays 0; error=1.
  - In both cases: digits, count and negative clear; return to IDLE; busy=0.
- Latency: enter event at edge k gives a value_valid high cycle following edge k+4.
- In CONVERT, digit, sign and enter events are ignored (not queued).
- clear in CONVERT aborts: return to IDLE, no valid pulse, entry cleared, value_out retained.
- Enter with count 0 converts to 0. Negative zero yields value_out=0, no error.
- reset asserted mid-CONVERT: immediate return to reset values; no valid pulse after release.

Test Plan:
- Keys 1,2,3 then enter → unit=3, ten=2, hundred=1 during entry; busy for 4 cycles; value_out=9'h07B; single value_valid pulse.
- Keys 2,5,6, sign, enter → value_out=9'h100 (-256), valid pulse. Same digits without sign → error=1, no pulse, value_out unchanged.
- Four digits 4,5,6,7 → 4th ignored; shows 4/5/6. Digit 4'hC ignored. digit_key held high 20 cycles enters one digit.
- enter and digit_key rising in the same cycle → conversion of the prior entry only; the digit is dropped. clear during CONVERT → no pulse, busy drops next cycle.
- Sign only, then enter → value_out=0, valid. Enter with no digits → value_out=0, valid.
- reset asserted asynchronously mid-cycle during CONVERT → all outputs 0 immediately; after release, a new entry 7 gives value_out=9'h007.

Source files
------------

// File: rtl/decimal_entry_if.sv
// Key inputs and result/echo outputs of the decimal entry block.
// The master drives the keys and the slave is the entry logic.
interface decimal_entry_if #(
    parameter int WIDTH = 9
);
    logic [3:0]       digit;
    logic             digit_key;
    logic             sign_key;
    logic             enter_key;
    logic             clear_key;
    logic [WIDTH-1:0] value_out;
    logic             value_valid;
    logic             error;
    logic             busy;
    logic [3:0]       unit;
    logic [3:0]       ten;
    logic [3:0]       hundred;
    logic             negative;

    modport master (
        output digit, digit_key, sign_key, enter_key, clear_key,
        input  value_out, value_valid, error, busy, unit, ten, hundred, negative
    );

    modport slave (
        input  digit, digit_key, sign_key, enter_key, clear_key,
        output value_out, value_valid, error, busy, unit, ten, hundred, negative
    );
endinterface

// File: rtl/decimal_entry.sv
// Signed decimal keypad entry: collects BCD digits, converts them serially to
// a two's-complement value and pulses value_valid on success.
//
// state   | meaning
// IDLE    | collecting digits and sign, waiting for enter
// CONVERT | three multiply-accumulate steps, then range check
module decimal_entry #(
    parameter int WIDTH   = 9,
    parameter int NDIGITS = 3
) (
    input logic          clock,
    input logic          reset,
    decimal_entry_if.slave bus
);
    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [9:0] POS_MAX = 10'((1 << (WIDTH - 1)) - 1);
    localparam logic [9:0] NEG_MAX = 10'(1 << (WIDTH - 1));

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [9:0]       acc_q, acc_d;
    logic [3:0]       hundred_q, hundred_d;
    logic [3:0]       ten_q, ten_d;
    logic [3:0]       unit_q, unit_d;
    logic [CW-1:0]    count_q, count_d;
    logic             negative_q, negative_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [3:0]       keys_q;

    logic [3:0] keys_now;
    logic [3:0] ev;
    logic       ev_clear, ev_enter, ev_digit, ev_sign;
    logic [3:0] step_digit;
    logic [9:0] acc_next;
    logic [9:0] acc_neg;
    logic       in_range;

    assign keys_now = {bus.clear_key, bus.enter_key, bus.digit_key, bus.sign_key};
    assign ev       = keys_now & ~keys_q;
    assign ev_clear = ev[3];
    assign ev_enter = ev[2];
    assign ev_digit = ev[1];
    assign ev_sign  = ev[0];

    always_comb begin
        case (step_q)
            2'd0:    step_digit = hundred_q;
            2'd1:    step_digit = ten_q;
            default: step_digit = unit_q;
        endcase
    end

    // x10 as shift-and-add; acc never exceeds 99 before the last step
    assign acc_next = (acc_q << 3) + (acc_q << 1) + {6'd0, step_digit};
    assign acc_neg  = 10'd0 - acc_q;
    assign in_range = negative_q ? (acc_q <= NEG_MAX) : (acc_q <= POS_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            acc_q      <= '0;
            hundred_q  <= '0;
            ten_q      <= '0;
            unit_q     <= '0;
            count_q    <= '0;
            negative_q <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            keys_q     <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            hundred_q  <= hundred_d;
            ten_q      <= ten_d;
            unit_q     <= unit_d;
            count_q    <= count_d;
            negative_q <= negative_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            keys_q     <= keys_now;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        acc_d      = acc_q;
        hundred_d  = hundred_q;
        ten_d      = ten_q;
        unit_d     = unit_q;
        count_d    = count_q;
        negative_d = negative_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                if (ev_clear) begin
                    hundred_d  = '0;
                    ten_d      = '0;
                    unit_d     = '0;
                    count_d    = '0;
                    negative_d = 1'b0;
                    error_d    = 1'b0;
                end else if (ev_enter) begin
                    state_d = CONVERT;
                    acc_d   = '0;
                    step_d  = '0;
                end else if (ev_digit) begin
                    error_d = 1'b0;
                    if (bus.digit <= 4'd9 && count_q < CW'(NDIGITS)) begin
                        hundred_d = ten_q;
                        ten_d     = unit_q;
                        unit_d    = bus.digit;
                        count_d   = count_q + 1'b1;
                    end
                end else if (ev_sign) begin
                    negative_d = ~negative_q;
                end
            end

            CONVERT: begin
                if (ev_clear || step_q == 2'd3) begin
                    if (ev_clear) begin
                        error_d = 1'b0;
                    end else if (in_range) begin
                        value_d = negative_q ? acc_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        valid_d = 1'b1;
                        error_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d    = IDLE;
                    hundred_d  = '0;
                    ten_d      = '0;
                    unit_d     = '0;
                    count_d    = '0;
                    negative_d = 1'b0;
                end else begin
                    acc_d  = acc_next;
                    step_d = step_q + 2'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.value_out   = value_q;
    assign bus.value_valid = valid_q;
    assign bus.error       = error_q;
    assign bus.busy        = (state_q == CONVERT);
    assign bus.unit        = unit_q;
    assign bus.ten         = ten_q;
    assign bus.hundred     = hundred_q;
    assign bus.negative    = negative_q;
endmodule

// File: tb/tb_decimal_entry.sv
// Self-checking bench for decimal_entry: vector table, randomized entries
// against an arithmetic reference model, and hand-written corner sequences.
module tb_decimal_entry;
    logic clock;
    logic reset;

    decimal_entry_if #(.WIDTH(9)) bus ();

    decimal_entry #(.WIDTH(9), .NDIGITS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int m_value = 0;
    int q[$];

    typedef struct {
        int d[4];
        int nd;
        bit sgn;
        int eh, et, eu;
        int ev;
        bit ee;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press_digit(input int d);
        bus.digit     = 4'(d);
        bus.digit_key = 1'b1;
        tick();
        bus.digit_key = 1'b0;
        tick();
    endtask

    task automatic press_sign();
        bus.sign_key = 1'b1;
        tick();
        bus.sign_key = 1'b0;
        tick();
    endtask

    task automatic press_clear();
        bus.clear_key = 1'b1;
        tick();
        bus.clear_key = 1'b0;
        tick();
    endtask

    // Called right after the enter edge; sample 1 is the cycle following it.
    task automatic wait_conv(output int busy_n, output int valid_n, output int valid_at);
        busy_n = 0;
        valid_n = 0;
        valid_at = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) tick();
            if (bus.busy) busy_n++;
            if (bus.value_valid) begin
                valid_n++;
                valid_at = i;
            end
        end
    endtask

    task automatic do_enter(output int busy_n, output int valid_n, output int valid_at);
        bus.enter_key = 1'b1;
        tick();
        bus.enter_key = 1'b0;
        wait_conv(busy_n, valid_n, valid_at);
    endtask

    task automatic check_conv(input string tag, input int busy_n, input int valid_n,
                              input int valid_at, input int ev, input bit ee);
        check({tag, " value"}, bus.value_out, 32'(ev));
        check({tag, " error"}, bus.error, 32'(ee));
        check({tag, " pulses"}, valid_n, ee ? 0 : 1);
        if (!ee) check({tag, " latency"}, valid_at, 5);
        check({tag, " busy"}, busy_n, 4);
        check({tag, " cleared"}, {bus.hundred, bus.ten, bus.unit, 3'd0, bus.negative}, 0);
    endtask

    initial begin
        int bn, vn, va;
        int mag, nops, d;
        bit neg, ok;

        bus.digit = '0;
        bus.digit_key = 1'b0;
        bus.sign_key = 1'b0;
        bus.enter_key = 1'b0;
        bus.clear_key = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("reset outputs", {23'd0, bus.value_out, bus.value_valid, bus.error, bus.busy,
              bus.negative, bus.unit, bus.ten, bus.hundred}, 0);
        reset = 1'b0;
        tick();

        tbl[0] = '{'{1, 2, 3, 0}, 3, 1'b0, 1, 2, 3, 'h07B, 1'b0};
        tbl[1] = '{'{2, 5, 6, 0}, 3, 1'b1, 2, 5, 6, 'h100, 1'b0};
        tbl[2] = '{'{2, 5, 6, 0}, 3, 1'b0, 2, 5, 6, 'h100, 1'b1};
        tbl[3] = '{'{4, 5, 6, 7}, 4, 1'b0, 4, 5, 6, 'h100, 1'b1};
        tbl[4] = '{'{12, 3, 0, 0}, 2, 1'b0, 0, 0, 3, 'h003, 1'b0};
        tbl[5] = '{'{0, 0, 0, 0}, 0, 1'b1, 0, 0, 0, 'h000, 1'b0};
        tbl[6] = '{'{9, 0, 0, 0}, 1, 1'b0, 0, 0, 9, 'h009, 1'b0};
        tbl[7] = '{'{2, 5, 5, 0}, 3, 1'b0, 2, 5, 5, 'h0FF, 1'b0};
        tbl[8] = '{'{1, 2, 8, 0}, 3, 1'b1, 1, 2, 8, 'h180, 1'b0};

        foreach (tbl[r]) begin
            for (int j = 0; j < tbl[r].nd; j++) press_digit(tbl[r].d[j]);
            if (tbl[r].sgn) press_sign();
            check($sformatf("tbl%0d display", r),
                  {bus.hundred, bus.ten, bus.unit, 3'd0, bus.negative},
                  {4'(tbl[r].eh), 4'(tbl[r].et), 4'(tbl[r].eu), 3'd0, tbl[r].sgn});
            do_enter(bn, vn, va);
            check_conv($sformatf("tbl%0d", r), bn, vn, va, tbl[r].ev, tbl[r].ee);
        end
        m_value = 'h180;

        // randomized entries against an arithmetic model
        for (int n = 0; n < 30; n++) begin
            q.delete();
            neg = 1'b0;
            nops = $urandom_range(0, 6);
            for (int k = 0; k < nops; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    press_sign();
                    neg = !neg;
                end else begin
                    d = $urandom_range(0, 12);
                    press_digit(d);
                    if (d <= 9 && q.size() < 3) q.push_back(d);
                end
            end
            check($sformatf("rnd%0d unit", n), bus.unit, q.size() >= 1 ? q[q.size()-1] : 0);
            check($sformatf("rnd%0d ten", n), bus.ten, q.size() >= 2 ? q[q.size()-2] : 0);
            check($sformatf("rnd%0d hundred", n), bus.hundred, q.size() >= 3 ? q[0] : 0);
            check($sformatf("rnd%0d negative", n), bus.negative, 32'(neg));
            mag = 0;
            foreach (q[i]) mag = mag * 10 + q[i];
            ok = neg ? (mag <= 256) : (mag <= 255);
            if (ok) m_value = neg ? ((512 - mag) % 512) : mag;
            do_enter(bn, vn, va);
            check_conv($sformatf("rnd%0d", n), bn, vn, va, m_value, !ok);
        end

        // digit_key held for 20 cycles enters one digit
        bus.digit = 4'd8;
        bus.digit_key = 1'b1;
        repeat (20) tick();
        bus.digit_key = 1'b0;
        tick();
        check("hold digit", {bus.hundred, bus.ten, bus.unit}, 12'h008);
        press_clear();
        check("clear entry", {bus.hundred, bus.ten, bus.unit}, 0);

        // enter and digit in the same cycle: digit dropped, prior entry converted
        press_digit(1);
        press_digit(2);
        bus.digit = 4'd5;
        bus.digit_key = 1'b1;
        bus.enter_key = 1'b1;
        tick();
        bus.digit_key = 1'b0;
        bus.enter_key = 1'b0;
        wait_conv(bn, vn, va);
        m_value = 12;
        check_conv("same-cycle", bn, vn, va, m_value, 1'b0);

        // clear during CONVERT aborts
        press_digit(4);
        bus.enter_key = 1'b1;
        tick();
        bus.enter_key = 1'b0;
        tick();
        check("abort busy before", bus.busy, 1);
        bus.clear_key = 1'b1;
        tick();
        bus.clear_key = 1'b0;
        check("abort busy drops", bus.busy, 0);
        vn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.value_valid) vn++;
        end
        check("abort no pulse", vn, 0);
        check("abort value kept", bus.value_out, m_value);
        check("abort entry cleared", bus.unit, 0);

        // error cleared by a new digit, and by clear
        press_digit(9); press_digit(9); press_digit(9);
        do_enter(bn, vn, va);
        check_conv("999", bn, vn, va, m_value, 1'b1);
        press_digit(1);
        check("digit clears error", bus.error, 0);
        press_clear();
        press_digit(9); press_digit(9); press_digit(9);
        do_enter(bn, vn, va);
        check("error again", bus.error, 1);
        press_clear();
        check("clear clears error", bus.error, 0);

        // asynchronous reset in the middle of a conversion
        press_digit(5);
        bus.enter_key = 1'b1;
        tick();
        bus.enter_key = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async reset", {23'd0, bus.value_out, bus.value_valid, bus.error, bus.busy,
              bus.negative, bus.unit, bus.ten, bus.hundred}, 0);
        tick();
        tick();
        reset = 1'b0;
        vn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.value_valid || bus.busy) vn++;
        end
        check("no pulse after reset", vn, 0);
        press_digit(7);
        do_enter(bn, vn, va);
        check_conv("after reset", bn, vn, va, 'h007, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
